// File: rtl/jk_excitation_driver_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM states,
// excitation pair encodings and the excitation-table lookup.
package jk_excitation_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // {j,k} excitation pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Excitation table with don't-cares resolved to 0, except that a state
  // change may be encoded as toggle when toggle_pref is set.
  function automatic logic [1:0] jk_encode(input logic cur,
                                           input logic tgt,
                                           input logic toggle_pref);
    logic [1:0] jk;
    jk = JK_HOLD;
    if (cur != tgt) begin
      if (toggle_pref) jk = JK_TOG;
      else             jk = tgt ? JK_SET : JK_RST;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_tgt_fifo.sv
// 1-bit synchronous FIFO holding pending target bits. Pushes while full and
// pops while empty are ignored; head data is visible combinationally.
module jk_tgt_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Converts a stream of desired next-state bits into one-cycle J/K excitation
// pulses for an external JK flop and checks the flop's Q afterwards.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | j/k low, waiting for a queued target
// ST_DRIVE | excitation pair on j/k for exactly one cycle
// ST_CHECK | flop has sampled j/k; compare q_fb with the target
module jk_excitation_driver
  import jk_excitation_driver_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter bit          TOGGLE_PREF = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic             tgt_q;
  logic             j_q;
  logic             k_q;
  logic             err_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] done_count_q;
  logic [1:0]       jk_d;
  logic             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tgt_valid),
    .din_i   (tgt_bit),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The flop's current state is taken from q_fb on the pop edge and folded
  // straight into the registered pair, so no separate copy is kept.
  assign jk_d     = jk_encode(q_fb, fifo_head, TOGGLE_PREF);
  assign fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_CHECK));

  // Sequencer: pop, drive one cycle, check, then chain or go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tgt_q        <= 1'b0;
      j_q          <= 1'b0;
      k_q          <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      done_count_q <= '0;
    end else begin
      j_q <= 1'b0;
      k_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            tgt_q      <= fifo_head;
            {j_q, k_q} <= jk_d;
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          done_count_q <= done_count_q + CNT_ONE;
          if (q_fb != tgt_q) begin
            err_q <= 1'b1;
            if (err_count_q != '1) err_count_q <= err_count_q + CNT_ONE;
          end
          if (fifo_pop) begin
            tgt_q      <= fifo_head;
            {j_q, k_q} <= jk_d;
            state_q    <= ST_DRIVE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tgt_ready  = !fifo_full;
  assign j          = j_q;
  assign k          = k_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset encoding with
// 8-bit counters, toggle encoding with 2-bit counters) share one stimulus
// stream, each driving its own JK flop model.
module tb_jk_excitation_driver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_bit;
  logic       stuck;
  logic       flop_clr;
  logic [1:0] q_fb = '0;
  logic [1:0] j_w, k_w, rdy_w, busy_w, err_w;
  logic [7:0] ec0, dc0;
  logic [1:0] ec1, dc1;

  int total = 0;
  int bad   = 0;

  // transaction-level reference state
  bit          m_fifo[$];
  int          ecnt     = 0;
  int          last_pop = -10;
  bit          infl     = 1'b0;
  logic [1:0]  m_jk[2];
  bit          m_err[2];
  int          m_errc[2];
  int          m_done[2];
  int          m_mod[2] = '{256, 4};

  always #5 clk = ~clk;

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(8), .TOGGLE_PREF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy_w[0]), .j(j_w[0]), .k(k_w[0]), .q_fb(q_fb[0]),
    .busy(busy_w[0]), .err(err_w[0]), .err_count(ec0), .done_count(dc0));

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(2), .TOGGLE_PREF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(rdy_w[1]), .j(j_w[1]), .k(k_w[1]), .q_fb(q_fb[1]),
    .busy(busy_w[1]), .err(err_w[1]), .err_count(ec1), .done_count(dc1));

  // external JK flops (optionally stuck at 0)
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (flop_clr || stuck) q_fb[i] <= 1'b0;
      else q_fb[i] <= (j_w[i] & ~q_fb[i]) | (~k_w[i] & q_fb[i]);
    end
  end

  function automatic logic [1:0] enc(logic cur, logic tgt, bit tog);
    if (cur == tgt) return 2'b00;
    if (tog) return 2'b11;
    return tgt ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference by one edge, then compare all outputs.
  // Timing rule: target popped at edge p shows on j/k after p, is sampled by
  // the flop at p+1 and judged at p+2, where the next pop may also happen.
  task automatic tick();
    logic [1:0]  qp;
    int          occ;
    bit          popd;
    logic [31:0] ec, dc;
    qp  = q_fb;
    occ = m_fifo.size();
    @(posedge clk);
    #1;
    ecnt++;
    if (rst) begin
      m_fifo.delete();
      last_pop = -10;
      for (int i = 0; i < 2; i++) begin
        m_jk[i] = 2'b00; m_err[i] = 1'b0; m_errc[i] = 0; m_done[i] = 0;
      end
    end else begin
      if (ecnt - last_pop == 2) begin
        for (int i = 0; i < 2; i++) begin
          m_done[i] = (m_done[i] + 1) % m_mod[i];
          if (qp[i] != infl) begin
            m_err[i] = 1'b1;
            if (m_errc[i] < m_mod[i] - 1) m_errc[i]++;
          end
        end
      end
      popd = 1'b0;
      if (m_fifo.size() > 0 && ecnt - last_pop >= 2) begin
        infl     = m_fifo.pop_front();
        last_pop = ecnt;
        popd     = 1'b1;
      end
      for (int i = 0; i < 2; i++) m_jk[i] = popd ? enc(qp[i], infl, i == 1) : 2'b00;
      if (tgt_valid && occ < DEPTH) m_fifo.push_back(tgt_bit);
    end
    for (int i = 0; i < 2; i++) begin
      ec = (i == 0) ? {24'b0, ec0} : {30'b0, ec1};
      dc = (i == 0) ? {24'b0, dc0} : {30'b0, dc1};
      chk($sformatf("j%0d@%0d", i, ecnt), {31'b0, j_w[i]}, {31'b0, m_jk[i][1]});
      chk($sformatf("k%0d@%0d", i, ecnt), {31'b0, k_w[i]}, {31'b0, m_jk[i][0]});
      chk($sformatf("ready%0d@%0d", i, ecnt), {31'b0, rdy_w[i]},
          {31'b0, (m_fifo.size() < DEPTH)});
      chk($sformatf("busy%0d@%0d", i, ecnt), {31'b0, busy_w[i]},
          {31'b0, (m_fifo.size() > 0) || (ecnt - last_pop <= 1)});
      chk($sformatf("err%0d@%0d", i, ecnt), {31'b0, err_w[i]}, {31'b0, m_err[i]});
      chk($sformatf("errcnt%0d@%0d", i, ecnt), ec, m_errc[i]);
      chk($sformatf("donecnt%0d@%0d", i, ecnt), dc, m_done[i]);
    end
  endtask

  task automatic push(bit b);
    tgt_valid = 1'b1;
    tgt_bit   = b;
    tick();
  endtask

  task automatic idle(int n);
    tgt_valid = 1'b0;
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    bit seq_a[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit seq_e[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; tgt_valid = 1'b0; tgt_bit = 1'b0; stuck = 1'b0; flop_clr = 1'b1;
    tick();
    tick();
    flop_clr = 1'b0;
    rst      = 1'b0;

    // basic sequence 1,1,0,0,1 from q=0
    foreach (seq_a[n]) push(seq_a[n]);
    idle(14);
    chk("doneA0", {24'b0, dc0}, 32'd5);
    chk("doneA1", {30'b0, dc1}, 32'd1);
    chk("errA0", {31'b0, err_w[0]}, 32'd0);
    chk("qA0", {31'b0, q_fb[0]}, 32'd1);

    // continuous valid: fills FIFO, ready drops, order preserved
    for (int n = 0; n < 12; n++) push($urandom_range(0, 1) == 1);
    idle(12);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      tgt_valid = ($urandom_range(0, 3) != 0);
      tgt_bit   = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle(12);

    // reset while DRIVE with three entries still queued
    foreach (seq_e[n]) push(seq_e[n]);
    rst = 1'b1;
    tgt_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstJ0", {31'b0, j_w[0]}, 32'd0);
    chk("rstK0", {31'b0, k_w[0]}, 32'd0);
    chk("rstBusy0", {31'b0, busy_w[0]}, 32'd0);
    chk("rstReady0", {31'b0, rdy_w[0]}, 32'd1);
    chk("rstDone0", {24'b0, dc0}, 32'd0);
    idle(8);

    // flop stuck at 0: every '1' target fails
    stuck = 1'b1;
    for (int n = 0; n < 3; n++) push(1'b1);
    idle(8);
    chk("stuckErrc0", {24'b0, ec0}, 32'd3);
    chk("stuckDone0", {24'b0, dc0}, 32'd3);
    chk("stuckErr0", {31'b0, err_w[0]}, 32'd1);
    for (int n = 0; n < 2; n++) push(1'b1);
    idle(8);
    chk("satErrc1", {30'b0, ec1}, 32'd3);
    chk("satErrc0", {24'b0, ec0}, 32'd5);
    stuck = 1'b0;

    // more random traffic after the flop recovers; err stays sticky
    for (int n = 0; n < 60; n++) begin
      tgt_valid = ($urandom_range(0, 1) == 1);
      tgt_bit   = ($urandom_range(0, 1) == 1);
      tick();
    end
    idle(12);
    chk("stickyErr1", {31'b0, err_w[1]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
Transmit-side counterpart to a JK flip-flop. Accepts a stream of desired next-state bits, converts each one into a one-cycle J/K excitation pair using the JK excitation table, and drives an external JK flip-flop with that pair. It reads the flop's Q back and checks that the flop reached the requested state. The block sits between a bit-stream producer and any JK-flop-based storage element, and serves as a self-checking stimulus engine for flop-level blocks.

Parameters:
DEPTH, 4, target FIFO entries (power of two, at least 2)
CNT_W, 8, width of err_count and done_count
TOGGLE_PREF, 0, 1 = encode state changes as J=K=1 (toggle); 0 = encode them as set/reset

Ports:
clk  input  1  rising-edge clock, shared with the driven flop
rst  input  1  synchronous, active-high reset
tgt_valid  input  1  producer has a target bit
tgt_bit  input  1  desired flop Q after the excitation
tgt_ready  output  1  FIFO can accept (not full)
j  output  1  J excitation to the flop (registered)
k  output  1  K excitation to the flop (registered)
q_fb  input  1  Q fed back from the driven flop
busy  output  1  FSM not IDLE, or FIFO not empty
err  output  1  sticky mismatch flag
err_count  output  CNT_W  number of mismatches (saturating)
done_count  output  CNT_W  number of completed targets (wraps)

Behaviour:
- Reset state: j=0, k=0, err=0, err_count=0, done_count=0, FIFO empty, FSM=IDLE. tgt_ready is 1 in the first cycle after reset.
- FIFO: push when tgt_valid && tgt_ready. tgt_ready = !full, so a push presented while full is ignored. Push and pop in the same cycle are legal, including when full (that cycle's push is blocked by ready=0) and when empty with a push pending (no bypass; the pop waits one cycle). Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: j=k=0. If the FIFO is not empty:
  - pop the head into tgt_r;
  - latch cur_r <= q_fb;
  - go to DRIVE.
- Encoding, registered on entry to DRIVE:
  - cur=0, tgt=0: J=0, K=0 (hold).
  - cur=1, tgt=1: J=0, K=0 (hold).
  - cur=0, tgt=1: J=1, K=0; J=K=1 if TOGGLE_PREF=1.
  - cur=1, tgt=0: J=0, K=1; J=K=1 if TOGGLE_PREF=1.
  - Don't-care inputs are resolved to 0, except in the toggle case above.
- DRIVE: j/k are held for exactly one cycle. The flop samples them at the clock edge that ends DRIVE. Next state is CHECK, with j=k=0 registered.
- CHECK: compare q_fb with tgt_r.
  - Mismatch: err <= 1 and err_count increments, saturating at all-ones.
  - done_count increments on every CHECK, wrapping.
  - If the FIFO is not empty, pop and go directly to DRIVE, latching cur_r <= q_fb. Otherwise go to IDLE.
- Latency: 1 cycle from a target in an idle, non-empty FIFO to j/k asserted; verdict 2 cycles after the pop. Sustained throughput is one target per 2 cycles.
- err clears only on rst.
- Reset mid-operation: FIFO flushed, j/k forced to 0 in the next cycle, counters cleared. An in-flight target is discarded without being counted.
- busy = (state != IDLE) || !empty.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/DRIVE/CHECK);
  - localparams for the encoding pairs (JK_HOLD=2'b00, JK_SET=2'b10, JK_RST=2'b01, JK_TOG=2'b11);
  - a function jk_encode(cur, tgt, toggle_pref) returning {j,k}.
- One sub-module: jk_tgt_fifo, a 1-bit synchronous FIFO with DEPTH, push/pop/full/empty.

Test Plan:
- Reference JK flop with q reset to 0. Push targets 1,1,0,0,1 with TOGGLE_PREF=0 -> j/k sequence 10,00,01,00,10; q follows 1,1,0,0,1; err=0; done_count=5.
- Same targets with TOGGLE_PREF=1 -> j/k sequence 11,00,11,00,11; q identical; err=0.
- tgt_valid held high with the drain stalled -> tgt_ready drops after DEPTH (4) pushes. The 5th bit is not accepted until the first pop, and exactly 4 bits appear at j/k in order.
- Flop model forced stuck-at-0, push 1,1,1 -> err rises in the first CHECK; err_count=3, done_count=3. With CNT_W=2 and 5 failures -> err_count stays at 3.
- Assert rst during DRIVE with 3 entries queued -> next cycle j=k=0, busy=0, tgt_ready=1, done_count=0; the dropped targets never appear.
- Push and pop in the same cycle with the FIFO holding 1 entry -> occupancy unchanged, order preserved; done_count increments by 1 per CHECK.
